// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus received-byte outputs of the UART receiver.
// master = receiver side (samples rx, drives byte/status), slave = consumer side.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    input  rx,
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_err,
    output parity_err
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_err,
    input  parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and one-cycle result strobes.
// Optional even parity (8E1) when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int unsigned BAUD_END  = 56,
  parameter int unsigned BAUD_MID  = BAUD_END / 2,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       rstn,
  uart_rx_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(BAUD_END + 1);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(BAUD_END);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_MID);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
`endif

  logic                 rx_s1_q, rx_s2_q, rx_s3_q;
  logic                 fall_c;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_busy_q, rx_busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 parity_err_q, parity_err_d;
`endif

  // Two-flop synchroniser plus one delay flop for start-edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= bus.rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign fall_c = rx_s3_q & ~rx_s2_q;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      rx_busy_q    <= rx_busy_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = (baud_cnt_q == CNT_END) ? '0 : baud_cnt_q + CNT_W'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_d    = START;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      START: begin
        if (baud_cnt_q == CNT_MID) begin
          if (rx_s2_q) begin
            state_d = IDLE;
          end else begin
            // Skip one count: cancels the synchroniser lag so samples sit mid-bit
            baud_cnt_d = baud_cnt_q + CNT_W'(2);
          end
        end else if (baud_cnt_q == CNT_END) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_cnt_q == CNT_MID) begin
          shift_d   = {rx_s2_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end else if ((baud_cnt_q == CNT_END) && (bit_cnt_q == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_cnt_q == CNT_MID) begin
          par_d = rx_s2_q;
        end else if (baud_cnt_q == CNT_END) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_cnt_q == CNT_MID) begin
          if (rx_s2_q) begin
            // Return to IDLE mid stop bit so a back-to-back start edge is caught
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift_q, par_q}) begin
              parity_err_d = 1'b1;
            end else begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end
`else
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s2_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) begin
      baud_cnt_d = '0;
    end
    rx_busy_d = (state_d != IDLE);
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_busy   = rx_busy_q;
  assign bus.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver, the receive-side counterpart to the team's uart_tx. Synchronises the asynchronous serial input and detects the start-bit falling edge. Samples each bit at mid-period and presents the received byte with a one-cycle valid strobe. Sits between the board RX pin and the command/debug front-end driving the SDRAM controller.

Parameters:
BAUD_END, 56, last value of the baud counter; bit period = BAUD_END+1 clk cycles (56 is the simulation value; 5207 for 9600 baud at 50 MHz)
BAUD_MID, BAUD_END/2, baud-counter value at which a bit is sampled
DATA_BITS, 8, data bits per frame, LSB first

Ports:
clk  input  1  system clock, single clock domain
rstn  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
rx_data  output  8  last good received byte, held until next good frame
rx_valid  output  1  one-cycle pulse: rx_data updated this cycle
rx_busy  output  1  high from start-edge detection until return to IDLE
frame_err  output  1  one-cycle pulse: stop bit sampled low
parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN)

Behaviour:
- Reset (rstn low, async): state=IDLE, rx_data=8'h00, rx_valid=0, rx_busy=0, frame_err=0, parity_err=0, baud_cnt=0, bit_cnt=0, synchroniser flops=1.
- rx passes through 2 flops (rx_s1, rx_s2) and a third flop (rx_s3) for edge detection. Falling edge = rx_s3 & ~rx_s2. All logic uses rx_s2 only.
- baud_cnt runs only in non-IDLE states. It counts 0..BAUD_END and then wraps to 0. It clears to 0 on entering START.
- States:
  - IDLE: on falling edge, go to START and set rx_busy=1.
  - START: at baud_cnt==BAUD_MID, if rx_s2==1 (glitch), go to IDLE with no output pulses. Otherwise the start bit is confirmed and baud_cnt is re-phased so the later samples land mid-bit. At baud_cnt==BAUD_END go to DATA.
  - DATA: at each BAUD_MID sample, shift rx_s2 into bit 7 of the shift register (right shift, LSB first) and increment bit_cnt. After the DATA_BITS-th sample and the following BAUD_END, go to PARITY (macro) or STOP.
  - STOP: at BAUD_MID sample:
    - rx_s2==1: rx_data<=shift register and rx_valid=1 for the next cycle only. Go to IDLE in the same cycle, so the next start edge can be accepted during the second half of the stop bit (back-to-back frames supported).
    - rx_s2==0: frame_err=1 for one cycle, rx_data unchanged, go to BREAK.
  - BREAK: wait until rx_s2==1, then go to IDLE. A held-low line never re-triggers a frame.
- rx_busy=0 exactly when state==IDLE.
- Latency: rx_valid asserts 3 + (9×(BAUD_END+1)+BAUD_MID) ±1 clk after the rx start-bit falling edge.
- rx_valid, frame_err and parity_err are mutually exclusive pulses; never high two cycles in a row.
- Falling edges on rx outside IDLE are ignored.
- Reset asserted mid-frame aborts immediately to reset values; no partial byte is ever presented.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: frame is 8E1. State PARITY is inserted between DATA and STOP and samples the parity bit at BAUD_MID. In STOP with a good stop bit:
  - XOR of the 8 data bits and the parity bit ==0: rx_valid pulses as normal.
  - Otherwise: parity_err pulses for one cycle instead, and rx_data is unchanged.
  - A bad stop bit gives frame_err only; parity_err is not raised.
- Not defined: 8N1 only, no PARITY state, parity_err tied 0.

Test Plan:
- Reset, rx held 1 for 200 clk -> all outputs 0, rx_busy 0.
- Send 0xA5 (BAUD_END=56) -> one rx_valid pulse with rx_data=8'hA5, frame_err 0, latency within the stated ±1.
- Send 0x00 then 0xFF back-to-back, with the second start edge 29 clk into the first stop bit -> two rx_valid pulses, data 8'h00 then 8'hFF.
- 10-clk low glitch on idle rx -> rx_busy pulses high ~BAUD_MID cycles, then IDLE; no rx_valid or frame_err; rx_data unchanged.
- Send 0x3C with stop bit 0, then hold rx low 1000 clk -> single frame_err pulse, no rx_valid, rx_data keeps previous 8'hFF, no new frame until rx returns high.
- rstn pulsed low mid-DATA of 0x55 -> outputs at reset values immediately; next clean 0x81 is received correctly. With UART_RX_PARITY_EN: 0x81 with parity bit 1 -> parity_err pulse, no rx_valid.
